frame_write_arbiter: RTL

FRAME_WRITE_ARBITER -- requirements
Module: frame_write_arbiter

---
 rtl/frame_write_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/frame_write_arbiter.sv
// Purpose: round-robin arbiter that turns four channels' frame write requests into AXI burst commands.
// Latency: an eligible channel seen in IDLE produces cmd_valid on the next cycle; write_done follows burst_done by one cycle.
// Backpressure: cmd_valid/cmd_addr/cmd_ch hold until cmd_ready; one burst outstanding until burst_done.
module frame_write_arbiter #(
  parameter int          BURST_LEN       = 16,
  parameter int          BURSTS_PER_LINE = 40,
  parameter int          LINES_PER_FRAME = 360,
  parameter logic [27:0] LINE_STRIDE     = 28'd1280
) (
  input  logic        axi_aclk,
  input  logic        axi_areset,
  input  logic [3:0]  write_req,
  output logic [3:0]  write_done,
  input  logic [27:0] write_start_addr1,
  input  logic [27:0] write_start_addr2,
  input  logic [27:0] write_start_addr3,
  input  logic [27:0] write_start_addr4,
  input  logic [3:0]  fifo_rdy,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [27:0] cmd_addr,
  output logic [1:0]  cmd_ch,
  output logic [7:0]  cmd_len,
  input  logic        burst_done,
  output logic        busy
);

  localparam int CW = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
  localparam int LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(BURSTS_PER_LINE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES_PER_FRAME - 1);
  localparam logic [27:0]   BURST_INC = 28'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q;
  logic [1:0]    cmd_ch_q;
  logic [27:0]   cmd_addr_q;
  logic [3:0]    write_done_q;
  logic          abort_q;
  // Per-channel frame position; addr_q is the next burst address, line_addr_q the current line start.
  logic [CW-1:0] col_q       [4];
  logic [LW-1:0] line_q      [4];
  logic [27:0]   addr_q      [4];
  logic [27:0]   line_addr_q [4];

  logic [3:0]    elig;
  logic          grant_vld;
  logic [1:0]    grant_idx;
  logic [1:0]    cand;
  logic [27:0]   start_addr;

  assign elig       = write_req & fifo_rdy & ~write_done_q;
  assign cmd_valid  = (state_q == CMD);
  assign busy       = (state_q != IDLE);
  assign cmd_addr   = cmd_addr_q;
  assign cmd_ch     = cmd_ch_q;
  assign cmd_len    = 8'(BURST_LEN - 1);
  assign write_done = write_done_q;

  // Round-robin winner: search descending starting just below the last granted index.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q - 2'(k);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Frame base address of the channel being granted.
  always_comb begin
    case (grant_idx)
      2'd3:    start_addr = write_start_addr1;
      2'd2:    start_addr = write_start_addr2;
      2'd1:    start_addr = write_start_addr3;
      default: start_addr = write_start_addr4;
    endcase
  end

  // State register.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic: grant, command handshake, wait for burst completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld)  state_d = CMD;
      CMD:     if (cmd_ready)  state_d = WAIT;
      WAIT:    if (burst_done) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Grant bookkeeping, per-channel address/counter advance, abort and frame-complete handling.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      ptr_q        <= 2'd0;
      cmd_ch_q     <= 2'd0;
      cmd_addr_q   <= 28'd0;
      write_done_q <= 4'd0;
      abort_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        col_q[i]       <= '0;
        line_q[i]      <= '0;
        addr_q[i]      <= '0;
        line_addr_q[i] <= '0;
      end
    end else begin
      write_done_q <= 4'd0;
      // A dropped request on a channel not currently owning the bus aborts its frame.
      for (int i = 0; i < 4; i++) begin
        if (!write_req[i] && !((state_q != IDLE) && (cmd_ch_q == 2'(i)))) begin
          col_q[i]       <= '0;
          line_q[i]      <= '0;
          addr_q[i]      <= '0;
          line_addr_q[i] <= '0;
        end
      end
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            ptr_q    <= grant_idx;
            cmd_ch_q <= grant_idx;
            abort_q  <= 1'b0;
            if ((col_q[grant_idx] == '0) && (line_q[grant_idx] == '0)) begin
              cmd_addr_q             <= start_addr;
              addr_q[grant_idx]      <= start_addr;
              line_addr_q[grant_idx] <= start_addr;
            end else begin
              cmd_addr_q <= addr_q[grant_idx];
            end
          end
        end
        CMD: begin
          if (!write_req[cmd_ch_q]) abort_q <= 1'b1;
        end
        WAIT: begin
          if (!write_req[cmd_ch_q]) abort_q <= 1'b1;
          if (burst_done) begin
            if (abort_q || !write_req[cmd_ch_q]) begin
              col_q[cmd_ch_q]       <= '0;
              line_q[cmd_ch_q]      <= '0;
              addr_q[cmd_ch_q]      <= '0;
              line_addr_q[cmd_ch_q] <= '0;
            end else if (col_q[cmd_ch_q] != COL_LAST) begin
              col_q[cmd_ch_q]  <= col_q[cmd_ch_q] + 1'b1;
              addr_q[cmd_ch_q] <= addr_q[cmd_ch_q] + BURST_INC;
            end else if (line_q[cmd_ch_q] != LINE_LAST) begin
              col_q[cmd_ch_q]       <= '0;
              line_q[cmd_ch_q]      <= line_q[cmd_ch_q] + 1'b1;
              line_addr_q[cmd_ch_q] <= line_addr_q[cmd_ch_q] + LINE_STRIDE;
              addr_q[cmd_ch_q]      <= line_addr_q[cmd_ch_q] + LINE_STRIDE;
            end else begin
              col_q[cmd_ch_q]        <= '0;
              line_q[cmd_ch_q]       <= '0;
              addr_q[cmd_ch_q]       <= '0;
              line_addr_q[cmd_ch_q]  <= '0;
              write_done_q[cmd_ch_q] <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
